// File: rtl/buttons_pkg.sv
// Shared types and helpers for the button event logic.
package buttons_pkg;

    typedef enum logic [1:0] {
        ARMING,
        IDLE,
        PRESSED,
        HELD
    } btn_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned frequency,
                                                 input int unsigned ms);
        return frequency / 1000 * ms;
    endfunction

    function automatic int unsigned max_cycles(input int unsigned a,
                                               input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_events_if.sv
// Debounced button levels in, per-button event pulses out.
interface button_events_if #(
    parameter int buttons_number = 5
);

    logic [buttons_number-1:0] button;
    logic [buttons_number-1:0] press;
    logic [buttons_number-1:0] click;
    logic [buttons_number-1:0] long_press;
    logic [buttons_number-1:0] repeat_pulse;
    logic [buttons_number-1:0] held;

    modport master (
        output button,
        input  press,
        input  click,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  button,
        output press,
        output click,
        output long_press,
        output repeat_pulse,
        output held
    );

endinterface

// File: rtl/button_event_unit.sv
// Single-button event FSM: press, click, long press and (with BUTTONS_REPEAT_EN) auto-repeat.
// Synchronous active-low reset; a button held through reset is ignored until released.
module button_event_unit
    import buttons_pkg::*;
#(
    parameter int unsigned LONG_CYC = 20,
    parameter int unsigned REP_CYC  = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic press,
    output logic click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int CNT_W = $clog2(max_cycles(LONG_CYC, REP_CYC));
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

    btn_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             press_d, click_d, long_d;
`ifdef BUTTONS_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYC - 1);
    logic             repeat_d;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ARMING;
            cnt        <= '0;
            press      <= 1'b0;
            click      <= 1'b0;
            long_press <= 1'b0;
`ifdef BUTTONS_REPEAT_EN
            repeat_pulse <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            press      <= press_d;
            click      <= click_d;
            long_press <= long_d;
`ifdef BUTTONS_REPEAT_EN
            repeat_pulse <= repeat_d;
`endif
        end
    end

    // A release always takes priority over a threshold or wrap in the same cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        press_d = 1'b0;
        click_d = 1'b0;
        long_d  = 1'b0;
`ifdef BUTTONS_REPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state)
            ARMING: begin
                if (!button) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (button) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!button) begin
                    state_d = IDLE;
                    click_d = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!button) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef BUTTONS_REPEAT_EN
                end else if (cnt == REP_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
`else
                end else begin
                    cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d = ARMING;
            end
        endcase
    end

`ifndef BUTTONS_REPEAT_EN
    assign repeat_pulse = 1'b0;
`endif

    assign held = (state == HELD);

endmodule

// File: rtl/button_events.sv
// Array of independent per-button event FSMs on one clock.
// Auto-repeat pulses are built only when BUTTONS_REPEAT_EN is defined.
module button_events
    import buttons_pkg::*;
#(
    parameter int unsigned frequency      = 100000000,
    parameter int unsigned buttons_number = 5,
    parameter int unsigned long_press_ms  = 1000,
    parameter int unsigned repeat_ms      = 200
) (
    input  logic            clock,
    input  logic            reset_n,
    button_events_if.slave  bus
);

    localparam int unsigned LONG_CYC = ms_to_cycles(frequency, long_press_ms);
    localparam int unsigned REP_CYC  = ms_to_cycles(frequency, repeat_ms);

    for (genvar i = 0; i < int'(buttons_number); i++) begin : g_unit
        button_event_unit #(
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC)
        ) u_unit (
            .clock        (clock),
            .reset_n      (reset_n),
            .button       (bus.button[i]),
            .press        (bus.press[i]),
            .click        (bus.click[i]),
            .long_press   (bus.long_press[i]),
            .repeat_pulse (bus.repeat_pulse[i]),
            .held         (bus.held[i])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events at 1 cycle/ms: long threshold 20 cycles, repeat every 5.
module tb_button_events;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    button_events_if #(.buttons_number(5)) bus ();

    button_events #(
        .frequency      (1000),
        .buttons_number (5),
        .long_press_ms  (20),
        .repeat_ms      (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.button = 5'b00000;
        tick();
        tick();
        checks++;
        if ({bus.press, bus.click, bus.long_press} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_pulses got %b expected %b",
                     {bus.press, bus.click, bus.long_press}, 15'd0);
        end
        checks++;
        if ({bus.repeat_pulse, bus.held} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_levels got %b expected %b",
                     {bus.repeat_pulse, bus.held}, 10'd0);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_click();
        logic [4:0] long_acc = '0;
        bus.button = 5'b00001;
        tick();
        checks++;
        if (bus.press !== 5'b00001 || bus.click !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL click_press got press=%b click=%b expected press=00001 click=00000",
                     bus.press, bus.click);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            long_acc |= bus.long_press;
        end
        checks++;
        if (bus.press !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL click_press_single got %b expected 00000", bus.press);
        end
        bus.button = 5'b00000;
        tick();
        long_acc |= bus.long_press;
        checks++;
        if (bus.click !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL click_pulse got %b expected 00001", bus.click);
        end
        tick();
        checks++;
        if (bus.click !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL click_single got %b expected 00000", bus.click);
        end
        checks++;
        if (long_acc !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL click_no_long got %b expected 00000", long_acc);
        end
    endtask

    // Button high for 61 sampled edges: press at 1, long at 21, repeats at 26,31,...,61.
    task automatic test_long_repeat();
        int   press_at  = -1;
        int   long_at   = -1;
        int   first_rep = -1;
        int   long_n    = 0;
        int   rep_n     = 0;
        int   click_n   = 0;
        int   exp_rep_n;
        int   exp_first;
        logic held_pre  = 1'b1;
        logic held_mid  = 1'b0;
`ifdef BUTTONS_REPEAT_EN
        exp_rep_n = 8;
        exp_first = 26;
`else
        exp_rep_n = 0;
        exp_first = -1;
`endif
        bus.button = 5'b00010;
        for (int i = 1; i <= 61; i++) begin
            tick();
            if (bus.press[1] && press_at < 0) press_at = i;
            if (bus.long_press[1]) begin
                long_n++;
                if (long_at < 0) long_at = i;
            end
            if (bus.repeat_pulse[1]) begin
                rep_n++;
                if (first_rep < 0) first_rep = i;
            end
            if (bus.click[1]) click_n++;
            if (i == 20) held_pre = bus.held[1];
            if (i == 40) held_mid = bus.held[1];
        end
        bus.button = 5'b00000;
        tick();
        if (bus.click[1]) click_n++;
        checks++;
        if (press_at != 1) begin
            errors++;
            $display("[TB] FAIL long_press_at got %0d expected 1", press_at);
        end
        checks++;
        if (long_at != 21 || long_n != 1) begin
            errors++;
            $display("[TB] FAIL long_at got cycle %0d count %0d expected cycle 21 count 1",
                     long_at, long_n);
        end
        checks++;
        if (rep_n != exp_rep_n || first_rep != exp_first) begin
            errors++;
            $display("[TB] FAIL repeat got count %0d first %0d expected count %0d first %0d",
                     rep_n, first_rep, exp_rep_n, exp_first);
        end
        checks++;
        if (held_pre !== 1'b0 || held_mid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_level got pre=%b mid=%b expected pre=0 mid=1",
                     held_pre, held_mid);
        end
        checks++;
        if (bus.held !== 5'b00000 || click_n != 0) begin
            errors++;
            $display("[TB] FAIL held_release got held=%b clicks=%0d expected held=00000 clicks=0",
                     bus.held, click_n);
        end
    endtask

    task automatic test_held_through_reset();
        logic [4:0] acc = '0;
        bus.button = 5'b11111;
        reset_n    = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            acc |= bus.press | bus.click | bus.long_press | bus.repeat_pulse | bus.held;
        end
        bus.button = 5'b00000;
        tick();
        acc |= bus.press | bus.click | bus.long_press | bus.repeat_pulse | bus.held;
        checks++;
        if (acc !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL armed_silent got %b expected 00000", acc);
        end
        bus.button = 5'b11111;
        tick();
        checks++;
        if (bus.press !== 5'b11111) begin
            errors++;
            $display("[TB] FAIL armed_press got %b expected 11111", bus.press);
        end
        bus.button = 5'b00000;
        tick();
        checks++;
        if (bus.click !== 5'b11111 || bus.press !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL armed_click got click=%b press=%b expected click=11111 press=00000",
                     bus.click, bus.press);
        end
    endtask

    // Reset lands on hold cycle 11; without it the long press would appear at cycle 21.
    task automatic test_reset_mid_press();
        logic [4:0] acc = '0;
        bus.button = 5'b10000;
        tick();
        checks++;
        if (bus.press !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL mid_press got %b expected 10000", bus.press);
        end
        for (int i = 2; i <= 10; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if ({bus.press, bus.click, bus.long_press, bus.repeat_pulse, bus.held} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs got %b expected %b",
                     {bus.press, bus.click, bus.long_press, bus.repeat_pulse, bus.held}, 25'd0);
        end
        for (int i = 12; i <= 21; i++) begin
            tick();
            acc |= bus.press | bus.click | bus.long_press | bus.repeat_pulse | bus.held;
        end
        bus.button = 5'b00000;
        tick();
        acc |= bus.press | bus.click | bus.long_press | bus.repeat_pulse | bus.held;
        checks++;
        if (acc !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL mid_reset_silent got %b expected 00000", acc);
        end
        bus.button = 5'b10000;
        tick();
        checks++;
        if (bus.press !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL mid_rearm_press got %b expected 10000", bus.press);
        end
        bus.button = 5'b00000;
        tick();
    endtask

    // Release sampled while the counter holds 19 (cycle 21): click wins over long press.
    task automatic test_release_on_threshold();
        logic [4:0] long_acc = '0;
        bus.button = 5'b00001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            long_acc |= bus.long_press;
        end
        bus.button = 5'b00000;
        tick();
        long_acc |= bus.long_press;
        checks++;
        if (bus.click !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL threshold_click got %b expected 00001", bus.click);
        end
        checks++;
        if (long_acc !== 5'b00000 || bus.held !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL threshold_no_long got long=%b held=%b expected long=00000 held=00000",
                     long_acc, bus.held);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.button = 5'b01000;
        tick();
        checks++;
        if (bus.press !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL simul_first_press got %b expected 01000", bus.press);
        end
        tick();
        bus.button = 5'b00100;
        tick();
        checks++;
        if (bus.press !== 5'b00100 || bus.click !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL simul_events got press=%b click=%b expected press=00100 click=01000",
                     bus.press, bus.click);
        end
        bus.button = 5'b00000;
        tick();
        checks++;
        if (bus.press !== 5'b00000 || bus.click !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL simul_release got press=%b click=%b expected press=00000 click=00100",
                     bus.press, bus.click);
        end
        tick();
    endtask

    // One-cycle taps back to back: click follows press by exactly one cycle.
    task automatic test_back_to_back();
        for (int n = 0; n < 2; n++) begin
            bus.button = 5'b00001;
            tick();
            checks++;
            if (bus.press !== 5'b00001 || bus.click !== 5'b00000) begin
                errors++;
                $display("[TB] FAIL tap%0d_press got press=%b click=%b expected press=00001 click=00000",
                         n, bus.press, bus.click);
            end
            bus.button = 5'b00000;
            tick();
            checks++;
            if (bus.press !== 5'b00000 || bus.click !== 5'b00001) begin
                errors++;
                $display("[TB] FAIL tap%0d_click got press=%b click=%b expected press=00000 click=00001",
                         n, bus.press, bus.click);
            end
        end
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        bus.button = 5'b00000;
        $display("[TB] starting button_events bench");
        test_reset();
        test_click();
        test_long_repeat();
        test_held_through_reset();
        test_reset_mid_press();
        test_release_on_threshold();
        test_simultaneous();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
